alu_writeback: RTL



---
 rtl/alu_writeback.sv | 136 +++++++++++++
 1 files changed

// File: rtl/alu_writeback.sv
// alu_writeback -- commit stage behind the ez8 ALU.
//
// Commits the execute instruction's ALU results into the architectural
// accumulator and the Z/C/GIE flags. It also registers a one-cycle
// register-file write and presents that pending write as a bypass entry.
// A two-state skip machine discards the next real instruction after a
// committed skip.
//
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   ex_valid, stall         execute slot is real / hold the stage
//   ex_addr, result         register operand address, ALU result
//   *_write, zout/cout/gieout  ALU write enables and flag values
//   skip, irq_take          skip-next request, interrupt entry (clears GIE)
//   accum, z, c, gie        architectural state (accum/c feed the ALU)
//   rf_wen/rf_waddr/rf_wdata   registered register-file write
//   fwd_valid/fwd_addr/fwd_data bypass view of the same write
//   squash                  execute instruction is being discarded
module alu_writeback (
    input  logic       clk,
    input  logic       reset,
    input  logic       ex_valid,
    input  logic       stall,
    input  logic [7:0] ex_addr,
    input  logic [7:0] result,
    input  logic       accum_write,
    input  logic       reg_write,
    input  logic       z_write,
    input  logic       c_write,
    input  logic       gie_write,
    input  logic       zout,
    input  logic       cout,
    input  logic       gieout,
    input  logic       skip,
    input  logic       irq_take,
    output logic [7:0] accum,
    output logic       z,
    output logic       c,
    output logic       gie,
    output logic       rf_wen,
    output logic [7:0] rf_waddr,
    output logic [7:0] rf_wdata,
    output logic       fwd_valid,
    output logic [7:0] fwd_addr,
    output logic [7:0] fwd_data,
    output logic       squash
);

    typedef enum logic {S_IDLE, S_ARMED} skip_state_e;

    skip_state_e state_q, state_d;
    logic [7:0]  accum_q, accum_d;
    logic        z_q, z_d;
    logic        c_q, c_d;
    logic        gie_q, gie_d;
    logic        rf_wen_q, rf_wen_d;
    logic [7:0]  rf_waddr_q, rf_waddr_d;
    logic [7:0]  rf_wdata_q, rf_wdata_d;

    logic skip_pending;
    logic commit;

    assign skip_pending = (state_q == S_ARMED);
    assign commit       = ex_valid & ~stall & ~skip_pending;

    always_comb begin
        state_d    = state_q;
        accum_d    = accum_q;
        z_d        = z_q;
        c_d        = c_q;
        gie_d      = gie_q;
        // The write strobe is a pulse: it only survives an edge when a new
        // committed reg_write reloads it, even while stalled.
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        if (commit) begin
            if (accum_write) accum_d = result;
            if (z_write)     z_d     = zout;
            if (c_write)     c_d     = cout;
            if (gie_write)   gie_d   = gieout;
            if (reg_write) begin
                rf_wen_d   = 1'b1;
                rf_waddr_d = ex_addr;
                rf_wdata_d = result;
            end
        end

        // Interrupt entry wins over a same-cycle GIE write.
        if (irq_take) gie_d = 1'b0;

        case (state_q)
            S_IDLE:  if (commit && skip) state_d = S_ARMED;
            // The first real, unstalled instruction is the one skipped;
            // its own skip request dies with it.
            S_ARMED: if (ex_valid && !stall) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            accum_q    <= 8'h00;
            z_q        <= 1'b0;
            c_q        <= 1'b0;
            gie_q      <= 1'b0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= 8'h00;
            rf_wdata_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            accum_q    <= accum_d;
            z_q        <= z_d;
            c_q        <= c_d;
            gie_q      <= gie_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign accum     = accum_q;
    assign z         = z_q;
    assign c         = c_q;
    assign gie       = gie_q;
    assign rf_wen    = rf_wen_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign fwd_valid = rf_wen_q;
    assign fwd_addr  = rf_waddr_q;
    assign fwd_data  = rf_wdata_q;
    assign squash    = ex_valid & skip_pending;

endmodule
